// File: rtl/inst_buffer.sv
// Dual-issue instruction queue between the branch predictor and decode.
// Optional stall counter enabled by defining INST_BUFFER_PERF_EN.
module inst_buffer #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push_en_1,
   input  logic          push_en_2,
   input  logic [31:0]   pc_1_i,
   input  logic [31:0]   pc_2_i,
   input  logic [31:0]   inst_1_i,
   input  logic [31:0]   inst_2_i,
   input  logic          is_branch_1_i,
   input  logic          is_branch_2_i,
   input  logic          taken_i,
   input  logic [31:0]   target_i,
   output logic          buf_ready_o,
`ifdef INST_BUFFER_PERF_EN
   output logic [31:0]   full_stall_cnt_o,
`endif
   input  logic          dec_ready_i,
   output logic          valid_1_o,
   output logic          valid_2_o,
   output logic [31:0]   pc_1_o,
   output logic [31:0]   pc_2_o,
   output logic [31:0]   inst_1_o,
   output logic [31:0]   inst_2_o,
   output logic          br_1_o,
   output logic          br_2_o,
   output logic          taken_1_o,
   output logic          taken_2_o,
   output logic [31:0]   target_1_o,
   output logic [31:0]   target_2_o
);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        br;
      logic        taken;
      logic [31:0] target;
   } entry_t;

   // Two free slots are required so a dual push can never overflow.
   localparam logic [AW:0] ReadyMax = (AW+1)'(DEPTH - 2);

   entry_t        mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;

   logic [AW-1:0] wr_addr_2;
   logic [AW-1:0] rd_addr_2;
   logic [1:0]    push_n;
   logic [1:0]    pop_m;
   logic          push_ok;
   entry_t        ent_1, ent_2;
   entry_t        rd_1, rd_2;

   always_comb begin
      buf_ready_o = (count_q <= ReadyMax);
      valid_1_o   = (count_q != '0);
      valid_2_o   = |count_q[AW:1];
      push_ok     = buf_ready_o & ~flush;
      push_n      = push_ok ? ({1'b0, push_en_1} + {1'b0, push_en_2}) : 2'd0;
      pop_m       = dec_ready_i ? ({1'b0, valid_1_o} + {1'b0, valid_2_o}) : 2'd0;
      wr_addr_2   = wr_ptr_q + AW'(push_en_1);
      rd_addr_2   = rd_ptr_q + AW'(1);
   end

   // Non-branch slots store zeroed prediction fields.
   always_comb begin
      ent_1.pc     = pc_1_i;
      ent_1.inst   = inst_1_i;
      ent_1.br     = is_branch_1_i;
      ent_1.taken  = is_branch_1_i & taken_i;
      ent_1.target = is_branch_1_i ? target_i : 32'h0;
      ent_2.pc     = pc_2_i;
      ent_2.inst   = inst_2_i;
      ent_2.br     = is_branch_2_i;
      ent_2.taken  = is_branch_2_i & taken_i;
      ent_2.target = is_branch_2_i ? target_i : 32'h0;
   end

   always_comb begin
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         wr_ptr_d = wr_ptr_q + AW'(push_n);
         rd_ptr_d = rd_ptr_q + AW'(pop_m);
         count_d  = count_q + (AW+1)'(push_n) - (AW+1)'(pop_m);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately not reset; validity comes from count alone.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         if (push_en_1) mem_q[wr_ptr_q] <= ent_1;
         if (push_en_2) mem_q[wr_addr_2] <= ent_2;
      end
   end

   always_comb begin
      rd_1       = valid_1_o ? mem_q[rd_ptr_q]  : '0;
      rd_2       = valid_2_o ? mem_q[rd_addr_2] : '0;
      pc_1_o     = rd_1.pc;
      inst_1_o   = rd_1.inst;
      br_1_o     = rd_1.br;
      taken_1_o  = rd_1.taken;
      target_1_o = rd_1.target;
      pc_2_o     = rd_2.pc;
      inst_2_o   = rd_2.inst;
      br_2_o     = rd_2.br;
      taken_2_o  = rd_2.taken;
      target_2_o = rd_2.target;
   end

`ifdef INST_BUFFER_PERF_EN
   logic [31:0] stall_cnt_q;

   // Flush does not clear the counter; it is a lifetime statistic.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
      end else if ((push_en_1 | push_en_2) & ~buf_ready_o & ~flush &
                   (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign full_stall_cnt_o = stall_cnt_q;
`endif

endmodule
